simon_playback_ctrl: RTL and testbench

// Sequencer for the Simon "Simon plays" phase. On a start pulse it rewinds the

---
 rtl/simon_playback_if.sv | 31 +++
 rtl/simon_playback_ctrl.sv | 167 ++++++++++++++++
 tb/tb_simon_playback_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/simon_playback_if.sv
// simon_playback_if
// Handshake and status bundle between the Simon top-level FSM (master) and
// the playback sequencer (slave).
//   start, abort, length          master -> slave
//   busy, done, prng_rerun,
//   prng_step, tone_en, led_en,
//   index                         slave -> master
interface simon_playback_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] length;
  logic             busy;
  logic             done;
  logic             prng_rerun;
  logic             prng_step;
  logic             tone_en;
  logic             led_en;
  logic [LEN_W-1:0] index;

  modport master (
    output start, abort, length,
    input  busy, done, prng_rerun, prng_step, tone_en, led_en, index
  );

  modport slave (
    input  start, abort, length,
    output busy, done, prng_rerun, prng_step, tone_en, led_en, index
  );
endinterface

// File: rtl/simon_playback_ctrl.sv
// simon_playback_ctrl
// Plays the "Simon plays" phase: rewinds the PRNG, then plays len tones, each
// a tone_en/led_en on-time followed by a silent gap ending in one PRNG step,
// and finally pulses done.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    simon_playback_if.slave: start/abort/length in; busy, done,
//          prng_rerun, prng_step, tone_en, led_en, index out (all registered)
// Configuration macro: SIMON_SPEEDUP_EN -- when defined, the tone on-time is
// halved for len >= 8 and quartered for len >= 16; gap length is unchanged.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; outputs quiet, index holds last value
// S_RERUN  | one-cycle prng_rerun pulse
// S_TONE   | tone_en/led_en high, counting down the on-time
// S_GAP    | silence, counting down; prng_step on the last gap cycle
// S_FINISH | one-cycle done pulse, busy still high
module simon_playback_ctrl #(
  parameter int TONE_CYCLES = 37_500_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int CNT_W       = 28,
  parameter int LEN_W       = 8
) (
  input  logic clk,
  input  logic reset,
  simon_playback_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RERUN,
    S_TONE,
    S_GAP,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] index_q;
  logic             busy_q;
  logic             done_q;
  logic             rerun_q;
  logic             step_q;
  logic             tone_q;
  logic             led_q;
  logic [CNT_W-1:0] tone_load;

`ifdef SIMON_SPEEDUP_EN
  localparam logic [CNT_W-1:0] TONE_LOAD_HALF    = CNT_W'((TONE_CYCLES >> 1) - 1);
  localparam logic [CNT_W-1:0] TONE_LOAD_QUARTER = CNT_W'((TONE_CYCLES >> 2) - 1);

  always_comb begin
    tone_load = TONE_LOAD;
    if (len_q >= LEN_W'(16))
      tone_load = TONE_LOAD_QUARTER;
    else if (len_q >= LEN_W'(8))
      tone_load = TONE_LOAD_HALF;
  end
`else
  assign tone_load = TONE_LOAD;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      len_q   <= '0;
      index_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rerun_q <= 1'b0;
      step_q  <= 1'b0;
      tone_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      rerun_q <= 1'b0;
      step_q  <= 1'b0;
      if (bus.abort) begin
        // Abort beats every transition; index deliberately keeps its value.
        state  <= S_IDLE;
        busy_q <= 1'b0;
        tone_q <= 1'b0;
        led_q  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              len_q   <= bus.length;
              index_q <= '0;
              busy_q  <= 1'b1;
              if (bus.length == '0) begin
                state  <= S_FINISH;
                done_q <= 1'b1;
              end else begin
                state   <= S_RERUN;
                rerun_q <= 1'b1;
              end
            end
          end
          S_RERUN: begin
            state  <= S_TONE;
            cnt    <= tone_load;
            tone_q <= 1'b1;
            led_q  <= 1'b1;
          end
          S_TONE: begin
            if (cnt == '0) begin
              state  <= S_GAP;
              cnt    <= GAP_LOAD;
              tone_q <= 1'b0;
              led_q  <= 1'b0;
              // A one-cycle gap is its own last cycle, so step right away.
              step_q <= (GAP_LOAD == '0);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_GAP: begin
            if (cnt == '0) begin
              index_q <= index_q + LEN_W'(1);
              if (index_q + LEN_W'(1) == len_q) begin
                state  <= S_FINISH;
                done_q <= 1'b1;
              end else begin
                state  <= S_TONE;
                cnt    <= tone_load;
                tone_q <= 1'b1;
                led_q  <= 1'b1;
              end
            end else begin
              cnt <= cnt - CNT_W'(1);
              // Registered pulse: raise it one cycle ahead so it lands on
              // the final gap cycle.
              step_q <= (cnt == CNT_W'(1));
            end
          end
          S_FINISH: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            tone_q <= 1'b0;
            led_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.prng_rerun = rerun_q;
  assign bus.prng_step  = step_q;
  assign bus.tone_en    = tone_q;
  assign bus.led_en     = led_q;
  assign bus.index      = index_q;

endmodule

// File: tb/tb_simon_playback_ctrl.sv
module tb_simon_playback_ctrl;

  localparam int TONE  = 4;
  localparam int GAP   = 2;
  localparam int LEN_W = 8;
`ifdef SIMON_SPEEDUP_EN
  localparam int DONE8 = 34;
`else
  localparam int DONE8 = 50;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  simon_playback_if #(.LEN_W(LEN_W)) bus ();

  simon_playback_ctrl #(
    .TONE_CYCLES(TONE),
    .GAP_CYCLES (GAP),
    .CNT_W      (8),
    .LEN_W      (LEN_W)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic             busy;
    logic             done;
    logic             rerun;
    logic             step;
    logic             tone;
    logic [LEN_W-1:0] index;
  } exp_t;

  int               cyc      = 0;
  bit               m_active = 1'b0;
  int               m_t0     = 0;
  int               m_len    = 0;
  int               m_end    = 0;
  logic [LEN_W-1:0] m_held   = '0;

  function automatic int tone_len(input int l);
`ifdef SIMON_SPEEDUP_EN
    if (l >= 16) return TONE >> 2;
    if (l >= 8) return TONE >> 1;
`endif
    return TONE;
  endfunction

  // Expected outputs during cycle c, derived from the run's start cycle.
  function automatic exp_t model_at(input int c);
    exp_t e;
    int k, p, j;
    e = '0;
    if (!m_active) begin
      e.index = m_held;
      return e;
    end
    e.busy = 1'b1;
    k = c - m_t0;
    if (m_len == 0) begin
      e.done = 1'b1;
      return e;
    end
    p = tone_len(m_len) + GAP;
    if (k == 1) begin
      e.rerun = 1'b1;
    end else if (k == 2 + m_len * p) begin
      e.done  = 1'b1;
      e.index = LEN_W'(m_len);
    end else begin
      j = k - 2;
      e.tone  = (j % p) < tone_len(m_len);
      e.step  = (j % p) == p - 1;
      e.index = LEN_W'(j / p);
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_held   <= '0;
      cyc      <= 0;
    end else begin
      if (bus.abort) begin
        if (m_active) begin
          m_held   <= model_at(cyc).index;
          m_active <= 1'b0;
        end
      end else if (m_active) begin
        if (cyc == m_end) begin
          m_active <= 1'b0;
          m_held   <= LEN_W'(m_len);
        end
      end else if (bus.start) begin
        m_active <= 1'b1;
        m_t0     <= cyc;
        m_len    <= int'(bus.length);
        m_end    <= (bus.length == '0) ? cyc + 1
                    : cyc + 2 + int'(bus.length) * (tone_len(int'(bus.length)) + GAP);
      end
      cyc <= cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    e = model_at(cyc);
    chk("busy",       32'(bus.busy),       32'(e.busy));
    chk("done",       32'(bus.done),       32'(e.done));
    chk("prng_rerun", 32'(bus.prng_rerun), 32'(e.rerun));
    chk("prng_step",  32'(bus.prng_step),  32'(e.step));
    chk("tone_en",    32'(bus.tone_en),    32'(e.tone));
    chk("led_en",     32'(bus.led_en),     32'(e.tone));
    chk("index",      32'(bus.index),      32'(e.index));
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic s, input logic a, input logic [LEN_W-1:0] l);
    bus.start  = s;
    bus.abort  = a;
    bus.length = l;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, '0);
      adv();
    end
  endtask

  // Three tones; an optional second start and a changed length mid-run.
  task automatic scn_len3(input int extra_start);
    for (int k = 0; k < 24; k++) begin
      drive(k == 0 || k == extra_start, 1'b0,
            (k > 0 && extra_start > 0) ? LEN_W'(7) : LEN_W'(3));
      if (k == 1)  chk("s1 rerun@1", 32'(bus.prng_rerun), 32'd1);
      if (k == 2)  chk("s1 tone@2", 32'(bus.tone_en), 32'd1);
      if (k == 5)  chk("s1 tone@5", 32'(bus.tone_en), 32'd1);
      if (k == 6)  chk("s1 tone@6", 32'(bus.tone_en), 32'd0);
      if (k == 7)  chk("s1 step@7", 32'(bus.prng_step), 32'd1);
      if (k == 13) chk("s1 step@13", 32'(bus.prng_step), 32'd1);
      if (k == 17) chk("s1 tone@17", 32'(bus.tone_en), 32'd1);
      if (k == 20) chk("s1 done@20", 32'(bus.done), 32'd1);
      if (k == 20) chk("s1 busy@20", 32'(bus.busy), 32'd1);
      if (k == 21) chk("s1 busy@21", 32'(bus.busy), 32'd0);
      if (k == 21) chk("s1 index@21", 32'(bus.index), 32'd3);
      adv();
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.length = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset busy",  32'(bus.busy),    32'd0);
    chk("reset tone",  32'(bus.tone_en), 32'd0);
    chk("reset index", 32'(bus.index),   32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(3);

    scn_len3(0);
    idle(3);
    scn_len3(5);
    idle(3);

    // length 0: straight to FINISH
    for (int k = 0; k < 5; k++) begin
      drive(k == 0, 1'b0, '0);
      if (k == 1) chk("s2 done@1", 32'(bus.done), 32'd1);
      if (k == 1) chk("s2 busy@1", 32'(bus.busy), 32'd1);
      if (k == 1) chk("s2 rerun@1", 32'(bus.prng_rerun), 32'd0);
      if (k == 2) chk("s2 busy@2", 32'(bus.busy), 32'd0);
      adv();
    end
    idle(2);

    // abort in the second tone
    for (int k = 0; k < 15; k++) begin
      drive(k == 0, k == 9, 8'd3);
      if (k == 9)  chk("s4 tone@9", 32'(bus.tone_en), 32'd1);
      if (k == 10) chk("s4 busy@10", 32'(bus.busy), 32'd0);
      if (k == 10) chk("s4 tone@10", 32'(bus.tone_en), 32'd0);
      if (k == 14) chk("s4 index@14", 32'(bus.index), 32'd1);
      adv();
    end
    idle(2);

    // start and abort together
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, k == 0, 8'd3);
      if (k == 1) chk("s5 busy@1", 32'(bus.busy), 32'd0);
      if (k == 1) chk("s5 rerun@1", 32'(bus.prng_rerun), 32'd0);
      adv();
    end

    // length 8 (on-time shortened when the speed-up build is selected)
    for (int k = 0; k < DONE8 + 3; k++) begin
      drive(k == 0, 1'b0, 8'd8);
      if (k == DONE8)     chk("s6 done", 32'(bus.done), 32'd1);
      if (k == DONE8 + 1) chk("s6 index", 32'(bus.index), 32'd8);
      adv();
    end
    idle(2);

    // randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [LEN_W-1:0] l;
      if (i == 1500) begin
        rst = 1'b1;
        #1;
        chk("async rst busy", 32'(bus.busy),    32'd0);
        chk("async rst tone", 32'(bus.tone_en), 32'd0);
        chk("async rst idx",  32'(bus.index),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
      r = $urandom_range(0, 9);
      if (r < 6)      l = LEN_W'($urandom_range(0, 4));
      else if (r < 8) l = LEN_W'($urandom_range(5, 9));
      else            l = LEN_W'($urandom_range(14, 18));
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0, l);
      adv();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
